sched_queue: RTL and testbench
==============================

Name: sched_queue

Overview:
- Scheduling queue between the front end (decode) and the execute stage.
- Buffers decoded micro-ops (iop, init step, 16-bit argument) in a small in-order FIFO.
- Returns feed-slot credit upstream and presents the head entry to execute with a valid/take handshake.
- Flushes on PC redirect. Reports whether any queued op will write the status flags.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- a_rst  in  1  reset, synchronous, active-high.
- id_feed_req  in  1  decode presents a valid micro-op this cycle.
- id_iop  in  32  decoded micro-op word; bit 21 = flag-writer (sf_busy).
- id_iop_init  in  3  initial micro-step index.
- id_arg  in  16  operand/argument.
- ex_feed_slot  out  1  queue can accept a push this cycle (not full).
- ex_flush  in  1  PC redirect; discard all queued entries.
- ex_take  in  1  execute consumes the head entry.
- ex_valid  out  1  head entry valid.
- ex_iop  out  32  head micro-op.
- ex_iop_init  out  3  head init step.
- ex_arg  out  16  head argument.
- ex_sf_pending  out  1  at least one queued entry has iop[21] set.
- q_count  out  PTR_W+1  occupancy, for debug and bench use.

Behaviour:
- **State:**
  - storage array of DEPTH x 51 bits
  - wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH)
  - count (PTR_W+1 bits)
  - sf_cnt (PTR_W+1 bits): number of entries with iop[21] set
- **Reset** (a_rst high at a clock edge):
  - wr_ptr, rd_ptr, count and sf_cnt all go to 0.
  - Storage contents are don't-care.
  - Outputs after reset: ex_valid=0, ex_feed_slot=1, ex_sf_pending=0, q_count=0.
  - ex_iop/ex_iop_init/ex_arg are don't-care while ex_valid=0.
  - Reset overrides flush, push and pop.
- **Combinational outputs, all from registered state only:**
  - ex_feed_slot = (count != DEPTH)
  - ex_valid = (count != 0)
  - ex_iop/ex_iop_init/ex_arg = storage[rd_ptr]
  - ex_sf_pending = (sf_cnt != 0)
- **Push** = id_feed_req & ex_feed_slot & ~ex_flush.
  - Writes {id_iop, id_iop_init, id_arg} at wr_ptr; wr_ptr increments.
  - id_feed_req while full is ignored. Decode holds its op, so no data is lost.
- **Pop** = ex_take & ex_valid & ~ex_flush.
  - rd_ptr increments.
  - ex_take while empty is ignored.
- **Count update:**
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged; legal at any non-empty, non-full occupancy
  - when full, a pop frees the slot only on the next cycle; there is no same-cycle fall-through
- **sf_cnt update:**
  - +1 when the pushed iop[21]=1
  - -1 when the popped head iop[21]=1
  - both together: net 0
- **Latency:**
  - a pushed entry is visible on ex_* one cycle after the push edge
  - there is no empty-queue bypass
- **Flush** (ex_flush=1 at an edge, a_rst low):
  - count, sf_cnt, wr_ptr and rd_ptr all go to 0.
  - A push or pop requested in the same cycle is discarded.
  - Next cycle: ex_valid=0, ex_feed_slot=1.
- **Ordering:** strict FIFO; entries are never reordered or duplicated.
- **Pointer wrap:** DEPTH-1 -> 0, with no bubble.

Decomposition:
- **Shared package (core_pkg):**
  - IOP_W=32, INIT_W=3, ARG_W=16
  - IOP_SF_BIT=21
  - queue entry struct/width constant, QE_W=51
- **Sub-module sched_queue_mem:**
  - DEPTH x QE_W register array
  - one write port (we, waddr, wdata), one asynchronous read port (raddr, rdata)
  - no reset
- sched_queue holds the pointers, counters and control.

Test Plan:
1. Reset, then idle -> ex_valid=0, ex_feed_slot=1, q_count=0, ex_sf_pending=0.
2. Push iop=0x0000_0001, init=3, arg=0xBEEF with take=0 -> next cycle ex_valid=1, ex_iop=0x1, ex_iop_init=3, ex_arg=0xBEEF, q_count=1. Pulse take -> next cycle ex_valid=0.
3. Push 4 ops (arg 0x10..0x13) with no take -> q_count=4, ex_feed_slot=0. A fifth push (arg 0x14) is ignored. Pop 4 in sequence -> ex_arg reads 0x10,0x11,0x12,0x13.
4. At q_count=2, assert push and take together for 6 cycles (args 0x20..0x25) -> q_count stays 2. Pops appear in order with pointer wrap and no bubble.
5. Push ops with iop[21]=1, 0, 1 -> ex_sf_pending=1. Pop the first two -> still 1. Pop the third -> 0.
6. At q_count=3 with sf_cnt=1, assert ex_flush together with id_feed_req and ex_take -> next cycle q_count=0, ex_valid=0, ex_sf_pending=0, ex_feed_slot=1. Assert a_rst mid-burst -> same state as test 1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the decode -> execute scheduling path.
// Provides field widths of a queued micro-op, the flag-writer bit
// position inside the iop word, and the packed queue-entry layout.
package core_pkg;

    localparam int IOP_W      = 32;
    localparam int INIT_W     = 3;
    localparam int ARG_W      = 16;
    localparam int IOP_SF_BIT = 21;
    localparam int QE_W       = IOP_W + INIT_W + ARG_W;

    // Field order fixes the storage layout: {iop, init, arg}.
    typedef struct packed {
        logic [IOP_W-1:0]  iop;
        logic [INIT_W-1:0] init;
        logic [ARG_W-1:0]  arg;
    } qentry_t;

endpackage

// File: rtl/sched_queue_mem.sv
// Storage array for the scheduling queue.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data (one packed queue entry)
//   raddr  - read address
//   rdata  - asynchronous read data
// No reset: contents are qualified by the occupancy count in the parent.
module sched_queue_mem
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [QE_W-1:0]  wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [QE_W-1:0]  rdata
);

    logic [QE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sched_queue.sv
// In-order scheduling queue between decode and execute.
// Ports:
//   clk, a_rst          - clock, synchronous active-high reset
//   id_feed_req         - decode offers a micro-op
//   id_iop/_init/_arg   - offered micro-op fields
//   ex_feed_slot        - queue not full (push accepted)
//   ex_flush            - PC redirect, discard all entries
//   ex_take             - execute consumes head entry
//   ex_valid            - head entry valid
//   ex_iop/_init/_arg   - head entry fields
//   ex_sf_pending       - some queued entry writes the status flags
//   q_count             - current occupancy
// All outputs derive from registered state; there is no empty bypass and
// no full-queue fall-through.
module sched_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               a_rst,
    input  logic               id_feed_req,
    input  logic [IOP_W-1:0]   id_iop,
    input  logic [INIT_W-1:0]  id_iop_init,
    input  logic [ARG_W-1:0]   id_arg,
    output logic               ex_feed_slot,
    input  logic               ex_flush,
    input  logic               ex_take,
    output logic               ex_valid,
    output logic [IOP_W-1:0]   ex_iop,
    output logic [INIT_W-1:0]  ex_iop_init,
    output logic [ARG_W-1:0]   ex_arg,
    output logic               ex_sf_pending,
    output logic [PTR_W:0]     q_count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   sf_cnt;

    qentry_t wr_entry;
    qentry_t head;
    logic    push;
    logic    pop;
    logic    push_sf;
    logic    pop_sf;

    assign ex_feed_slot  = (count != FULL_CNT);
    assign ex_valid      = (count != '0);
    assign ex_sf_pending = (sf_cnt != '0);
    assign q_count       = count;

    assign push    = id_feed_req & ex_feed_slot & ~ex_flush;
    assign pop     = ex_take & ex_valid & ~ex_flush;
    assign push_sf = push & id_iop[IOP_SF_BIT];
    assign pop_sf  = pop & head.iop[IOP_SF_BIT];

    always_comb begin
        wr_entry      = '0;
        wr_entry.iop  = id_iop;
        wr_entry.init = id_iop_init;
        wr_entry.arg  = id_arg;
    end

    sched_queue_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign ex_iop      = head.iop;
    assign ex_iop_init = head.init;
    assign ex_arg      = head.arg;

    always_ff @(posedge clk) begin
        if (a_rst || ex_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sf_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({push_sf, pop_sf})
                2'b10:   sf_cnt <= sf_cnt + 1'b1;
                2'b01:   sf_cnt <= sf_cnt - 1'b1;
                default: sf_cnt <= sf_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sched_queue.sv
module tb_sched_queue;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        id_feed_req;
    logic [31:0] id_iop;
    logic [2:0]  id_iop_init;
    logic [15:0] id_arg;
    logic        ex_feed_slot;
    logic        ex_flush;
    logic        ex_take;
    logic        ex_valid;
    logic [31:0] ex_iop;
    logic [2:0]  ex_iop_init;
    logic [15:0] ex_arg;
    logic        ex_sf_pending;
    logic [2:0]  q_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    sched_queue #(
        .DEPTH (4),
        .PTR_W (2)
    ) dut (
        .clk           (clk),
        .a_rst         (a_rst),
        .id_feed_req   (id_feed_req),
        .id_iop        (id_iop),
        .id_iop_init   (id_iop_init),
        .id_arg        (id_arg),
        .ex_feed_slot  (ex_feed_slot),
        .ex_flush      (ex_flush),
        .ex_take       (ex_take),
        .ex_valid      (ex_valid),
        .ex_iop        (ex_iop),
        .ex_iop_init   (ex_iop_init),
        .ex_arg        (ex_arg),
        .ex_sf_pending (ex_sf_pending),
        .q_count       (q_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_state(input string tag);
        check({tag, ".valid"}, 32'(ex_valid), 32'd0);
        check({tag, ".slot"},  32'(ex_feed_slot), 32'd1);
        check({tag, ".count"}, 32'(q_count), 32'd0);
        check({tag, ".sf"},    32'(ex_sf_pending), 32'd0);
    endtask

    initial begin
        a_rst       = 1'b1;
        id_feed_req = 1'b0;
        id_iop      = '0;
        id_iop_init = '0;
        id_arg      = '0;
        ex_flush    = 1'b0;
        ex_take     = 1'b0;
        step();
        step();
        a_rst = 1'b0;
        step();

        // 1: reset/idle
        idle_state("t1");

        // take while empty is ignored
        ex_take = 1'b1;
        step();
        ex_take = 1'b0;
        check("t1.take_empty", 32'(q_count), 32'd0);

        // 2: single push, one-cycle latency, then pop
        id_feed_req = 1'b1;
        id_iop      = 32'h0000_0001;
        id_iop_init = 3'd3;
        id_arg      = 16'hBEEF;
        step();
        id_feed_req = 1'b0;
        check("t2.valid", 32'(ex_valid), 32'd1);
        check("t2.iop",   ex_iop, 32'h1);
        check("t2.init",  32'(ex_iop_init), 32'd3);
        check("t2.arg",   32'(ex_arg), 32'hBEEF);
        check("t2.count", 32'(q_count), 32'd1);
        ex_take = 1'b1;
        step();
        ex_take = 1'b0;
        check("t2.valid_after_pop", 32'(ex_valid), 32'd0);

        // 3: fill, overflow ignored, drain in order
        id_iop      = 32'h0;
        id_iop_init = 3'd0;
        id_feed_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            id_arg = 16'(16'h10 + i);
            step();
        end
        check("t3.count_full", 32'(q_count), 32'd4);
        check("t3.slot_full",  32'(ex_feed_slot), 32'd0);
        id_arg = 16'h14;
        step();
        id_feed_req = 1'b0;
        check("t3.count_ovf", 32'(q_count), 32'd4);
        ex_take = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3.arg%0d", i), 32'(ex_arg), 32'(16'h10 + i));
            step();
        end
        ex_take = 1'b0;
        check("t3.count_empty", 32'(q_count), 32'd0);

        // 4: steady-state push+pop at occupancy 2, across pointer wrap
        id_feed_req = 1'b1;
        id_arg = 16'h30;
        step();
        id_arg = 16'h31;
        step();
        check("t4.count_pre", 32'(q_count), 32'd2);
        ex_take = 1'b1;
        for (int i = 0; i < 6; i++) begin
            id_arg = 16'(16'h20 + i);
            check($sformatf("t4.head%0d", i), 32'(ex_arg),
                  (i < 2) ? 32'(16'h30 + i) : 32'(16'h20 + i - 2));
            step();
            check($sformatf("t4.count%0d", i), 32'(q_count), 32'd2);
        end
        id_feed_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t4.tail%0d", i), 32'(ex_arg), 32'(16'h24 + i));
            step();
        end
        ex_take = 1'b0;
        check("t4.count_end", 32'(q_count), 32'd0);

        // 5: status-flag writer tracking
        id_feed_req = 1'b1;
        id_iop = 32'h0020_0000; id_arg = 16'h40; step();
        id_iop = 32'h0000_0000; id_arg = 16'h41; step();
        id_iop = 32'h0020_0000; id_arg = 16'h42; step();
        id_feed_req = 1'b0;
        check("t5.sf3", 32'(ex_sf_pending), 32'd1);
        ex_take = 1'b1;
        step();
        check("t5.sf_pop1", 32'(ex_sf_pending), 32'd1);
        step();
        check("t5.sf_pop2", 32'(ex_sf_pending), 32'd1);
        check("t5.arg_head3", 32'(ex_arg), 32'h42);
        step();
        ex_take = 1'b0;
        check("t5.sf_pop3", 32'(ex_sf_pending), 32'd0);

        // 6: flush overrides simultaneous push and pop
        id_feed_req = 1'b1;
        id_iop = 32'h0000_0000; id_arg = 16'h50; step();
        id_iop = 32'h0020_0000; id_arg = 16'h51; step();
        id_iop = 32'h0000_0000; id_arg = 16'h52; step();
        check("t6.count3", 32'(q_count), 32'd3);
        check("t6.sf1", 32'(ex_sf_pending), 32'd1);
        ex_flush = 1'b1;
        ex_take  = 1'b1;
        id_iop = 32'h0020_0000; id_arg = 16'h53;
        step();
        ex_flush = 1'b0;
        ex_take  = 1'b0;
        id_feed_req = 1'b0;
        idle_state("t6.flush");

        // queue usable right after flush
        id_feed_req = 1'b1;
        id_iop = 32'h0; id_arg = 16'h55;
        step();
        id_feed_req = 1'b0;
        check("t6.post_flush_arg", 32'(ex_arg), 32'h55);
        check("t6.post_flush_cnt", 32'(q_count), 32'd1);

        // reset in the middle of a push burst
        id_feed_req = 1'b1;
        id_iop = 32'h0020_0000; id_arg = 16'h60; step();
        a_rst = 1'b1;
        ex_take = 1'b1;
        id_arg = 16'h61;
        step();
        a_rst = 1'b0;
        ex_take = 1'b0;
        id_feed_req = 1'b0;
        idle_state("t6.reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
